// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;
  localparam int REG_W           = 5;
  localparam int WAIT_W          = 8;
  localparam int DEF_MULT_CYCLES = 4;
  localparam int DEF_DIV_CYCLES  = 32;
  localparam int DEF_MEM_TIMEOUT = 255;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} ctrl_state_e;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
  } stall_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
  } flush_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/md_busy_counter.sv
// Mult/div busy tracker: loads on an unstalled start, counts down, freezes while the pipe is held.
module md_busy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  input  logic freeze,
  output logic busy
);
  localparam int CW = $clog2(max_i(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [CW-1:0] cnt;
  logic          load;

  assign load = start && !freeze;
  // The start cycle itself counts as busy so a dependent op in ID is held right away.
  assign busy = load || (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
    else if (!freeze && cnt != '0)
      cnt <= cnt - CW'(1);
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, load-use and mult/div
// interlocks, and branch/overflow flushes resolved by fixed priority.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_usesMd,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_rw,
  input  logic             ex_mdStart,
  input  logic             ex_mdDiv,
  input  logic             branch_ex,
  input  logic             overflow_ex,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwr_reset,
  output logic             md_busy,
  output logic             err_timeout
);
  ctrl_state_e       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall, flush_br, load_use, md_stall, md_busy_raw;
  stall_t            stl;
  flush_t            fl;

  // A wait cycle in which memory completes is not a stall; the pipe advances.
  assign mem_stall = !dmem_ready && ((state == MEM_WAIT) || (state == RUN && mem_access));
  assign flush_br  = branch_ex || overflow_ex;
  assign load_use  = (state == RUN) && ex_memRead && (ex_rw != '0) &&
                     ((ex_rw == id_rs) || (ex_rw == id_rt));
  assign md_stall  = id_usesMd && md_busy_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: if (mem_access && !dmem_ready) begin
          state    <= MEM_WAIT;
          wait_cnt <= '0;
        end
        MEM_WAIT: begin
          if (dmem_ready)
            state <= RUN;
          else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state       <= ERR;
            wait_cnt    <= WAIT_W'(MEM_TIMEOUT);
            err_timeout <= 1'b1;
          end else
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ERR:     state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ex_mdStart),
    .is_div(ex_mdDiv),
    .freeze(mem_stall),
    .busy  (md_busy_raw)
  );

  assign md_busy = rst_n && md_busy_raw;

  // Priority chain: reset > memory stall > branch/overflow flush > ID interlocks.
  always_comb begin
    stl         = '0;
    fl          = '0;
    memwr_reset = 1'b0;
    if (!rst_n) begin
      fl          = '1;
      memwr_reset = 1'b1;
    end else if (mem_stall) begin
      stl         = '1;
      memwr_reset = 1'b1;
    end else if (flush_br) begin
      fl.ifid  = 1'b1;
      fl.idex  = 1'b1;
      fl.exmem = overflow_ex;
    end else if (load_use || md_stall) begin
      stl.pc   = 1'b1;
      stl.ifid = 1'b1;
      fl.idex  = 1'b1;
    end
  end

  assign pc_stall    = stl.pc;
  assign ifid_stall  = stl.ifid;
  assign idex_stall  = stl.idex;
  assign exmem_stall = stl.exmem;
  assign ifid_flush  = fl.ifid;
  assign idex_flush  = fl.idex;
  assign exmem_flush = fl.exmem;
endmodule
